// File: rtl/emissor_medida_dht11.sv
// emissor_medida_dht11: serialises one humidity/temperature reading as a 5-byte DHT11-style
// frame on a UART line (LSB first, idle high). Build macro PARIDADE_EN adds an even-parity bit per byte.
//
// state    | meaning
// INICIAL  | idle, line high, waiting for transmite
// PREPARA  | one cycle: reset byte index, compute checksum
// START    | start bit (low) for PERIODO_BIT cycles
// DADOS    | 8 data bits, LSB first
// STOP     | stop bit (high) for PERIODO_BIT cycles
// PROXIMO  | one-cycle inter-byte gap, selects next byte or ends frame
// FINAL    | one cycle: pronto pulse
// PARIDADE | even parity bit (PARIDADE_EN builds only)
module emissor_medida_dht11 #(
    parameter int PERIODO_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        transmite,
    input  logic [15:0] umidade,
    input  logic [15:0] temperatura,
    output logic        tx_serial,
    output logic        ocupado,
    output logic        pronto,
    output logic [2:0]  db_estado
);

    localparam int CW = (PERIODO_BIT > 1) ? $clog2(PERIODO_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PERIODO_BIT - 1);
    localparam logic [CW-1:0] CNT_UM  = CW'(1);

    typedef enum logic [2:0] {
        INICIAL  = 3'd0,
        PREPARA  = 3'd1,
        START    = 3'd2,
        DADOS    = 3'd3,
        STOP     = 3'd4,
        PROXIMO  = 3'd5,
        FINAL    = 3'd6,
        PARIDADE = 3'd7
    } estado_t;

    estado_t       estado;
    estado_t       prox_estado;
    logic [CW-1:0] cnt_bit;
    logic [2:0]    idx_bit;
    logic [2:0]    idx_byte;
    logic [15:0]   umid_q;
    logic [15:0]   temp_q;
    logic [7:0]    checksum;
    logic [7:0]    byte_atual;
    logic          fim_bit;
    logic          em_bit;
    logic          tx_prox;

    assign fim_bit = (cnt_bit == CNT_MAX);
    assign em_bit  = (estado == START) || (estado == DADOS) ||
                     (estado == STOP)  || (estado == PARIDADE);

    always_comb begin
        byte_atual = 8'h00;
        case (idx_byte)
            3'd0:    byte_atual = umid_q[15:8];
            3'd1:    byte_atual = umid_q[7:0];
            3'd2:    byte_atual = temp_q[15:8];
            3'd3:    byte_atual = temp_q[7:0];
            3'd4:    byte_atual = checksum;
            default: byte_atual = 8'h00;
        endcase
    end

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox_estado;
        end
    end

    // next-state logic
    always_comb begin
        prox_estado = estado;
        unique case (estado)
            INICIAL: if (transmite) prox_estado = PREPARA;
            PREPARA: prox_estado = START;
            START:   if (fim_bit) prox_estado = DADOS;
            DADOS: begin
                if (fim_bit && (idx_bit == 3'd7)) begin
`ifdef PARIDADE_EN
                    prox_estado = PARIDADE;
`else
                    prox_estado = STOP;
`endif
                end
            end
`ifdef PARIDADE_EN
            PARIDADE: if (fim_bit) prox_estado = STOP;
`endif
            STOP:    if (fim_bit) prox_estado = PROXIMO;
            PROXIMO: prox_estado = (idx_byte == 3'd4) ? FINAL : START;
            FINAL:   prox_estado = INICIAL;
            default: prox_estado = INICIAL;
        endcase
    end

    // outputs; tx_prox is registered into tx_serial so the line never glitches
    always_comb begin
        tx_prox   = 1'b1;
        ocupado   = 1'b0;
        pronto    = 1'b0;
        db_estado = estado;
        unique case (estado)
            INICIAL:  tx_prox = 1'b1;
            PREPARA:  ocupado = 1'b1;
            START: begin
                ocupado = 1'b1;
                tx_prox = 1'b0;
            end
            DADOS: begin
                ocupado = 1'b1;
                tx_prox = byte_atual[idx_bit];
            end
            PARIDADE: begin
                ocupado = 1'b1;
                tx_prox = ^byte_atual;
            end
            STOP:     ocupado = 1'b1;
            PROXIMO:  ocupado = 1'b1;
            FINAL:    pronto  = 1'b1;
            default:  tx_prox = 1'b1;
        endcase
    end

    // bit timer, bit/byte indices, latched frame and line register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_bit   <= '0;
            idx_bit   <= '0;
            idx_byte  <= '0;
            umid_q    <= '0;
            temp_q    <= '0;
            checksum  <= '0;
            tx_serial <= 1'b1;
        end else begin
            if (em_bit && !fim_bit) begin
                cnt_bit <= cnt_bit + CNT_UM;
            end else begin
                cnt_bit <= '0;
            end

            if ((estado == DADOS) && fim_bit) begin
                idx_bit <= idx_bit + 3'd1;
            end else if (estado == START) begin
                idx_bit <= '0;
            end

            if ((estado == INICIAL) && transmite) begin
                umid_q <= umidade;
                temp_q <= temperatura;
            end

            if (estado == PREPARA) begin
                idx_byte <= '0;
                checksum <= umid_q[15:8] + umid_q[7:0] + temp_q[15:8] + temp_q[7:0];
            end else if ((estado == PROXIMO) && (idx_byte != 3'd4)) begin
                idx_byte <= idx_byte + 3'd1;
            end

            tx_serial <= tx_prox;
        end
    end

endmodule

// File: tb/tb_emissor_medida_dht11.sv
// Bench for emissor_medida_dht11: a UART monitor decodes the line into a byte queue that is
// compared against expected bytes queued when each frame is started.
module tb_emissor_medida_dht11;

    localparam int P = 4;
`ifdef PARIDADE_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME_LEN = 5 * (BITS * P + 1) + 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        transmite = 1'b0;
    logic [15:0] umidade = 16'h0000;
    logic [15:0] temperatura = 16'h0000;
    logic        tx_serial;
    logic        ocupado;
    logic        pronto;
    logic [2:0]  db_estado;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       stop;
    } rx_t;

    rx_t        rx_q[$];
    logic [7:0] exp_q[$];

    emissor_medida_dht11 #(.PERIODO_BIT(P)) dut (
        .clock       (clock),
        .reset       (reset),
        .transmite   (transmite),
        .umidade     (umidade),
        .temperatura (temperatura),
        .tx_serial   (tx_serial),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    // line decoder: samples bit centres on falling clock edges, drops bytes cut by reset
    initial begin : monitor
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       ok;
        forever begin
            @(negedge clock);
            if (reset && tx_serial === 1'b0) begin
                ok = 1'b1;
                d  = 8'h00;
                p  = 1'b0;
                repeat (2) @(negedge clock);
                if (!reset || tx_serial !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (P) @(negedge clock);
                    d[i] = tx_serial;
                    if (!reset) ok = 1'b0;
                end
`ifdef PARIDADE_EN
                repeat (P) @(negedge clock);
                p = tx_serial;
                if (!reset) ok = 1'b0;
`endif
                repeat (P) @(negedge clock);
                s = tx_serial;
                if (!reset) ok = 1'b0;
                if (ok) rx_q.push_back({d, p, s});
            end
        end
    end

    task automatic start_frame(input logic [15:0] u, input logic [15:0] t,
                               input logic [39:0] bytes, input bit hold);
        @(negedge clock);
        umidade     = u;
        temperatura = t;
        transmite   = 1'b1;
        for (int i = 4; i >= 0; i--) exp_q.push_back(bytes[i*8 +: 8]);
        @(posedge clock);
        #1;
        if (!hold) transmite = 1'b0;
    endtask

    task automatic wait_pronto(output int n_pronto, output int n_fall);
        n_pronto = -1;
        n_fall   = -1;
        for (int i = 1; i <= FRAME_LEN + 20; i++) begin
            @(negedge clock);
            if (n_fall < 0 && tx_serial === 1'b0) n_fall = i;
            if (pronto === 1'b1) begin
                n_pronto = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (tx_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 || db_estado !== 3'd0) begin
            failures++;
            $display("FAIL reset_hold: tx=%b ocupado=%b pronto=%b estado=%0d, expected 1 0 0 0",
                     tx_serial, ocupado, pronto, db_estado);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (tx_serial !== 1'b1 || ocupado !== 1'b0 || db_estado !== 3'd0) begin
            failures++;
            $display("FAIL reset_idle: tx=%b ocupado=%b estado=%0d, expected 1 0 0",
                     tx_serial, ocupado, db_estado);
        end
    endtask

    task automatic test_basic();
        int np, nf;
        logic [7:0] e;
        rx_t r;
        start_frame(16'h3C00, 16'h1905, 40'h3C_00_19_05_5A, 1'b0);
        checks++;
        if (db_estado !== 3'd1 || ocupado !== 1'b1) begin
            failures++;
            $display("FAIL basic_accept: estado=%0d ocupado=%b, expected 1 1", db_estado, ocupado);
        end
        wait_pronto(np, nf);
        checks++;
        if (nf !== 3) begin
            failures++;
            $display("FAIL basic_latency: line fell at cycle %0d, expected 3", nf);
        end
        checks++;
        if (np !== FRAME_LEN) begin
            failures++;
            $display("FAIL basic_length: pronto at cycle %0d, expected %0d", np, FRAME_LEN);
        end
        checks++;
        if (ocupado !== 1'b0 || db_estado !== 3'd6) begin
            failures++;
            $display("FAIL basic_final: ocupado=%b estado=%0d, expected 0 6", ocupado, db_estado);
        end
        @(negedge clock);
        checks++;
        if (pronto !== 1'b0 || db_estado !== 3'd0) begin
            failures++;
            $display("FAIL basic_pulse: pronto=%b estado=%0d, expected 0 0", pronto, db_estado);
        end
        repeat (5) @(negedge clock);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                failures++;
                $display("FAIL basic_byte: got nothing, expected %h", e);
            end else begin
                r = rx_q.pop_front();
                if (r.data !== e || r.stop !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_byte: got %h stop=%b, expected %h stop=1", r.data, r.stop, e);
                end
`ifdef PARIDADE_EN
                checks++;
                if (r.par !== ^e) begin
                    failures++;
                    $display("FAIL basic_parity: got %b, expected %b for %h", r.par, ^e, e);
                end
`endif
            end
        end
        checks++;
        if (rx_q.size() != 0) begin
            failures++;
            $display("FAIL basic_extra: %0d extra bytes, expected 0", rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic test_checksum_wrap();
        int np, nf;
        logic [7:0] e;
        rx_t r;
        start_frame(16'hFFFF, 16'h8001, 40'hFF_FF_80_01_7F, 1'b0);
        wait_pronto(np, nf);
        checks++;
        if (np !== FRAME_LEN) begin
            failures++;
            $display("FAIL wrap_length: pronto at cycle %0d, expected %0d", np, FRAME_LEN);
        end
        repeat (5) @(negedge clock);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                failures++;
                $display("FAIL wrap_byte: got nothing, expected %h", e);
            end else begin
                r = rx_q.pop_front();
                if (r.data !== e || r.stop !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_byte: got %h stop=%b, expected %h stop=1", r.data, r.stop, e);
                end
            end
        end
    endtask

    task automatic test_busy();
        int np, nf;
        logic [7:0] e;
        rx_t r;
        start_frame(16'h1234, 16'h5678, 40'h12_34_56_78_14, 1'b0);
        repeat (60) @(negedge clock);
        transmite   = 1'b1;
        umidade     = 16'hAAAA;
        temperatura = 16'h5555;
        @(posedge clock);
        #1;
        transmite = 1'b0;
        checks++;
        if (ocupado !== 1'b1 || db_estado === 3'd1 || db_estado === 3'd0) begin
            failures++;
            $display("FAIL busy_ignore: ocupado=%b estado=%0d, expected 1 and mid-frame", ocupado, db_estado);
        end
        wait_pronto(np, nf);
        checks++;
        if (np !== FRAME_LEN - 60) begin
            failures++;
            $display("FAIL busy_length: pronto at cycle %0d, expected %0d", np, FRAME_LEN - 60);
        end
        repeat (30) @(negedge clock);
        checks++;
        if (db_estado !== 3'd0 || tx_serial !== 1'b1) begin
            failures++;
            $display("FAIL busy_noqueue: estado=%0d tx=%b, expected 0 1", db_estado, tx_serial);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                failures++;
                $display("FAIL busy_byte: got nothing, expected %h", e);
            end else begin
                r = rx_q.pop_front();
                if (r.data !== e || r.stop !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_byte: got %h stop=%b, expected %h stop=1", r.data, r.stop, e);
                end
            end
        end
        checks++;
        if (rx_q.size() != 0) begin
            failures++;
            $display("FAIL busy_extra: %0d extra bytes, expected 0", rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic test_reset_abort();
        int np, nf, k;
        logic [7:0] e;
        rx_t r;
        start_frame(16'h3C00, 16'h1905, 40'h3C_00_19_05_5A, 1'b0);
        k = 0;
        while (rx_q.size() < 2 && k < 200) begin
            @(negedge clock);
            k++;
        end
        k = 0;
        while (db_estado !== 3'd3 && k < 50) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (db_estado !== 3'd3 || rx_q.size() != 2) begin
            failures++;
            $display("FAIL abort_reach: estado=%0d bytes=%0d, expected 3 2", db_estado, rx_q.size());
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (tx_serial !== 1'b1 || ocupado !== 1'b0 || db_estado !== 3'd0 || pronto !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: tx=%b ocupado=%b estado=%0d pronto=%b, expected 1 0 0 0",
                     tx_serial, ocupado, db_estado, pronto);
        end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                failures++;
                $display("FAIL abort_pre_byte: got nothing, expected %h", e);
            end else begin
                r = rx_q.pop_front();
                if (r.data !== e) begin
                    failures++;
                    $display("FAIL abort_pre_byte: got %h, expected %h", r.data, e);
                end
            end
        end
        exp_q.delete();
        repeat (6) @(negedge clock);
        reset = 1'b1;
        repeat (60) @(negedge clock);
        checks++;
        if (rx_q.size() != 0 || tx_serial !== 1'b1) begin
            failures++;
            $display("FAIL abort_quiet: %0d bytes tx=%b, expected 0 bytes tx=1", rx_q.size(), tx_serial);
            rx_q.delete();
        end
        start_frame(16'h3C00, 16'h1905, 40'h3C_00_19_05_5A, 1'b0);
        wait_pronto(np, nf);
        checks++;
        if (np !== FRAME_LEN || nf !== 3) begin
            failures++;
            $display("FAIL abort_restart: pronto %0d fall %0d, expected %0d 3", np, nf, FRAME_LEN);
        end
        repeat (5) @(negedge clock);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                failures++;
                $display("FAIL abort_byte: got nothing, expected %h", e);
            end else begin
                r = rx_q.pop_front();
                if (r.data !== e || r.stop !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_byte: got %h stop=%b, expected %h stop=1", r.data, r.stop, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int np, nf;
        logic [7:0] e;
        rx_t r;
        start_frame(16'h1122, 16'h3344, 40'h11_22_33_44_AA, 1'b1);
        for (int i = 0; i < 5; i++) exp_q.push_back(exp_q[i]);
        wait_pronto(np, nf);
        checks++;
        if (np !== FRAME_LEN || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: pronto %0d ocupado=%b, expected %0d 0", np, ocupado, FRAME_LEN);
        end
        wait_pronto(np, nf);
        transmite = 1'b0;
        checks++;
        if (np !== FRAME_LEN + 1) begin
            failures++;
            $display("FAIL b2b_gap: second pronto after %0d cycles, expected %0d", np, FRAME_LEN + 1);
        end
        repeat (20) @(negedge clock);
        checks++;
        if (db_estado !== 3'd0) begin
            failures++;
            $display("FAIL b2b_stop: estado=%0d, expected 0", db_estado);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                failures++;
                $display("FAIL b2b_byte: got nothing, expected %h", e);
            end else begin
                r = rx_q.pop_front();
                if (r.data !== e || r.stop !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_byte: got %h stop=%b, expected %h stop=1", r.data, r.stop, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_checksum_wrap();
        test_busy();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
